// File: rtl/mem_cmd_initiator_if.sv
// Request/response port plus TX/RX FIFO pair seen by the memory command initiator.
// master = the initiator itself, slave = host logic and FIFOs around it.
interface mem_cmd_initiator_if #(
  parameter int FIFO_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [7:0]            req_addr;
  logic [7:0]            req_wdata;
  logic                  resp_valid;
  logic [7:0]            resp_data;
  logic                  resp_timeout;
  logic                  tx_fifo_full;
  logic                  tx_fifo_wr_en;
  logic [FIFO_WIDTH-1:0] dout;
  logic                  rx_fifo_empty;
  logic                  rx_fifo_rd_en;
  logic [FIFO_WIDTH-1:0] din;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  tx_fifo_full, rx_fifo_empty, din,
    output req_ready, resp_valid, resp_data, resp_timeout,
    output tx_fifo_wr_en, dout, rx_fifo_rd_en
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output tx_fifo_full, rx_fifo_empty, din,
    input  req_ready, resp_valid, resp_data, resp_timeout,
    input  tx_fifo_wr_en, dout, rx_fifo_rd_en
  );
endinterface

// File: rtl/mem_cmd_initiator.sv
// Serializes one read/write request into command bytes for the TX FIFO and, for
// reads, collects the single echoed byte from the RX FIFO under a timeout guard.
module mem_cmd_initiator #(
  parameter int FIFO_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  mem_cmd_initiator_if.master bus,
  output logic [5:0]          state_leds
);
  localparam int         CW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] CMD_RD = 8'd48;
  localparam logic [7:0] CMD_WR = 8'd49;

  // One-hot encoding doubles as the LED vector.
  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    SEND_CMD  = 6'b000010,
    SEND_ADDR = 6'b000100,
    SEND_DATA = 6'b001000,
    WAIT_RESP = 6'b010000,
    CAPTURE   = 6'b100000
  } state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_timeout_q, resp_timeout_d;
  logic [7:0]            resp_data_q, resp_data_d;
  logic [7:0]            tx_byte;
  logic                  send;
  logic                  push;

  always_comb begin
    state_d           = state_q;
    wr_d              = wr_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    dout_d            = dout_q;
    cnt_d             = '0;
    armed_d           = 1'b0;
    resp_valid_d      = 1'b0;
    resp_timeout_d    = 1'b0;
    resp_data_d       = resp_data_q;
    tx_byte           = 8'd0;
    bus.req_ready     = 1'b0;
    bus.rx_fifo_rd_en = 1'b0;

    unique case (state_q)
      SEND_CMD:  tx_byte = wr_q ? CMD_WR : CMD_RD;
      SEND_ADDR: tx_byte = addr_q;
      SEND_DATA: tx_byte = wdata_q;
      default:   tx_byte = 8'd0;
    endcase

    // Reset masks the byte enables so an interrupted packet never leaks a byte.
    send              = (state_q inside {SEND_CMD, SEND_ADDR, SEND_DATA}) && !rst;
    push              = send && !bus.tx_fifo_full;
    bus.tx_fifo_wr_en = push;
    bus.dout          = send ? FIFO_WIDTH'(tx_byte) : dout_q;
    if (push) dout_d = FIFO_WIDTH'(tx_byte);

    unique case (state_q)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD:  if (push) state_d = SEND_ADDR;
      SEND_ADDR: if (push) state_d = wr_q ? SEND_DATA : WAIT_RESP;
      SEND_DATA: begin
        if (push) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = 8'd0;
        end
      end
      WAIT_RESP: begin
        // Entry cycle clears the counter; it counts from the following cycle.
        armed_d = 1'b1;
        if (!bus.rx_fifo_empty) begin
          bus.rx_fifo_rd_en = !rst;
          state_d           = CAPTURE;
        end else if (armed_q && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d        = IDLE;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_data_d    = 8'd0;
        end else begin
          cnt_d = armed_q ? cnt_q + 1'b1 : '0;
        end
      end
      CAPTURE: begin
        resp_data_d  = bus.din[7:0];
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_q           <= 1'b0;
      addr_q         <= 8'd0;
      wdata_q        <= 8'd0;
      dout_q         <= '0;
      cnt_q          <= '0;
      armed_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      dout_q         <= dout_d;
      cnt_q          <= cnt_d;
      armed_q        <= armed_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_data_q    <= resp_data_d;
    end
  end

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_timeout = resp_timeout_q;
  assign bus.resp_data    = resp_data_q;
  assign state_leds       = state_q;
endmodule

// File: tb/tb_mem_cmd_initiator.sv
// Directed plus randomized bench for mem_cmd_initiator, checked against a
// packet/latency model built from the protocol rules; it also owns the RX FIFO.
module tb_mem_cmd_initiator;
  localparam int         TO     = 8;
  localparam logic [7:0] CMD_RD = 8'h30;
  localparam logic [7:0] CMD_WR = 8'h31;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] state_leds;
  logic [7:0] rxq[$];
  int         nchk = 0;
  int         nerr = 0;

  mem_cmd_initiator_if #(.FIFO_WIDTH(8)) bus ();

  mem_cmd_initiator #(.FIFO_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_leds(state_leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction; fmask forces tx_fifo_full on given relative cycles, fpct adds
  // random backpressure, rxd = cycles after the last pushed byte until the echo
  // byte lands in the RX FIFO (-1 = never).
  task automatic txn(input string nm, input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [31:0] fmask, input int fpct, input int rxd, input logic [7:0] rxb);
    logic [7:0] expq[$];
    logic [7:0] gotq[$];
    int need, pushed, nfull, avail, nrd, lat, elast, w, elat, erd, pend, nb;
    logic [7:0] popb, rdata, edata;
    logic rto, eto, done;
    pushed = 0; nfull = 0; avail = -1; nrd = 0; lat = -1; pend = 0;
    popb = 8'd0; rdata = 8'd0; rto = 1'b0; done = 1'b0;
    need = wr ? 3 : 2;
    expq.push_back(wr ? CMD_WR : CMD_RD);
    expq.push_back(a);
    if (wr) expq.push_back(d);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    bus.tx_fifo_full = 1'b0;
    #1 chk({nm, ".ready"}, {31'd0, bus.req_ready}, 32'd1);

    for (int t = 1; t <= 200 && !done; t++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = 8'($urandom);
      bus.tx_fifo_full = (t < 32 && fmask[t]) || ($urandom_range(0, 99) < fpct);
      if (bus.tx_fifo_full && pushed < need) nfull++;
      if (t == avail) rxq.push_back(rxb);
      bus.rx_fifo_empty = (rxq.size() == 0);
      bus.din = pend ? popb : 8'($urandom);
      pend = 0;
      #1;
      if (bus.tx_fifo_wr_en) begin
        gotq.push_back(bus.dout);
        pushed++;
        if (pushed == need && rxd >= 0) avail = t + 1 + rxd;
      end
      if (bus.rx_fifo_rd_en) begin
        nrd++;
        if (rxq.size() > 0) begin popb = rxq.pop_front(); pend = 1; end
      end
      if (bus.resp_valid) begin
        done = 1'b1; lat = t; rdata = bus.resp_data; rto = bus.resp_timeout;
      end
    end

    // Every full cycle while bytes remain delays the packet by one cycle.
    elast = need + nfull;
    eto = 1'b0; edata = 8'd0; erd = 0;
    if (wr) elat = elast + 1;
    else begin
      w = elast + 1;
      if (rxd >= 0 && rxd <= TO) begin elat = w + rxd + 2; edata = rxb; erd = 1; end
      else begin elat = w + TO + 1; eto = 1'b1; end
    end

    chk({nm, ".resp_seen"}, {31'd0, done}, 32'd1);
    chk({nm, ".nbytes"}, gotq.size(), need);
    nb = (gotq.size() < need) ? gotq.size() : need;
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s.byte%0d", nm, i), {24'd0, gotq[i]}, {24'd0, expq[i]});
    chk({nm, ".latency"}, lat, elat);
    chk({nm, ".resp_data"}, {24'd0, rdata}, {24'd0, edata});
    chk({nm, ".resp_timeout"}, {31'd0, rto}, {31'd0, eto});
    chk({nm, ".rd_pulses"}, nrd, erd);
    rxq.delete();
    bus.rx_fifo_empty = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pushes, bad;
    logic [15:0] pmask, rmask;
    logic [7:0] bq[$];
    logic [7:0] bexp[6];

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 8'd0; bus.req_wdata = 8'd0;
    bus.tx_fifo_full = 1'b0; bus.rx_fifo_empty = 1'b1; bus.din = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.state_leds", {26'd0, state_leds}, 32'h01);
    chk("rst.req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst.wr_en", {31'd0, bus.tx_fifo_wr_en}, 32'd0);
    chk("rst.rd_en", {31'd0, bus.rx_fifo_rd_en}, 32'd0);
    chk("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst.resp_timeout", {31'd0, bus.resp_timeout}, 32'd0);
    chk("rst.resp_data", {24'd0, bus.resp_data}, 32'd0);
    chk("rst.dout", {24'd0, bus.dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle.req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Stray RX data while idle must stay queued
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rx_fifo_empty = 1'b0;
      #1 if (bus.rx_fifo_rd_en) bad++;
    end
    chk("idle.no_rx_pop", bad, 0);
    bus.rx_fifo_empty = 1'b1;

    // Directed transactions
    txn("wr_basic", 1'b1, 8'h3C, 8'hA5, 32'd0, 0, -1, 8'h00);
    txn("rd_basic", 1'b0, 8'h10, 8'h00, 32'd0, 0, 0, 8'h7E);
    txn("wr_bp_addr", 1'b1, 8'h22, 8'h5A, 32'b11100, 0, -1, 8'h00);
    txn("rd_timeout", 1'b0, 8'h44, 8'h00, 32'd0, 0, -1, 8'h00);
    txn("rd_at_expiry", 1'b0, 8'h45, 8'h00, 32'd0, 0, TO, 8'hC3);
    txn("rd_after_expiry", 1'b0, 8'h46, 8'h00, 32'd0, 0, TO + 1, 8'h3C);
    txn("rd_bp", 1'b0, 8'h47, 8'h00, 32'b110, 0, 3, 8'h99);

    // Reset pulsed during SEND_DATA
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h12; bus.req_wdata = 8'h34;
    bus.tx_fifo_full = 1'b0;
    pushes = 0;
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1 if (bus.tx_fifo_wr_en) pushes++;
    end
    chk("rstmid.pushes_before", pushes, 2);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rstmid.wr_en_in_rst", {31'd0, bus.tx_fifo_wr_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.state_leds", {26'd0, state_leds}, 32'h01);
    chk("rstmid.req_ready", {31'd0, bus.req_ready}, 32'd1);
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      if (t > 0) begin @(negedge clk); #1; end
      if (bus.tx_fifo_wr_en || bus.resp_valid) bad++;
    end
    chk("rstmid.quiet_after", bad, 0);

    // Back-to-back writes with req_valid held
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h55; bus.req_wdata = 8'h66;
    bus.tx_fifo_full = 1'b0;
    pmask = 16'd0; rmask = 16'd0;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      if (t == 5) bus.req_valid = 1'b0;
      #1;
      pmask[t] = bus.tx_fifo_wr_en;
      rmask[t] = bus.resp_valid;
      if (bus.tx_fifo_wr_en) bq.push_back(bus.dout);
    end
    chk("b2b.push_cycles", {16'd0, pmask}, 32'b11101110);
    chk("b2b.resp_cycles", {16'd0, rmask}, 32'b100010000);
    chk("b2b.nbytes", bq.size(), 6);
    bexp = '{CMD_WR, 8'h55, 8'h66, CMD_WR, 8'h55, 8'h66};
    for (int i = 0; i < 6 && i < bq.size(); i++)
      chk($sformatf("b2b.byte%0d", i), {24'd0, bq[i]}, {24'd0, bexp[i]});

    // Randomized traffic
    for (int n = 0; n < 20; n++) begin
      int rxd;
      rxd = int'($urandom_range(0, 11)) - 1;
      txn($sformatf("rand%0d", n), 1'($urandom), 8'($urandom), 8'($urandom),
          32'd0, int'($urandom_range(0, 50)), rxd, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
